sdram_pattern_tester: RTL
=========================

// Module: sdram_pattern_tester
// PURPOSE
//  Command-port client that sits directly upstream of the SDRAM controller. Drives its
//  cmdTrigger/cmdAddr/cmdWrite/cmdWriteData port and consumes cmdReadData/cmdReadDataValid.
//  On start: writes an address-derived pattern over [ADDR_FIRST..ADDR_LAST], reads it back,
//  compares each word, reports pass/fail, error count and first failing address (board bring-up).
// PARAMETERS
//  ADDR_FIRST      23'h000000  first word address tested (inclusive)
//  ADDR_LAST       23'h7FFFFF  last word address tested (inclusive); must be >= ADDR_FIRST
//  PATTERN_SEED    16'hA5C3    expected data = addr[15:0] ^ addr[22:7] ^ PATTERN_SEED
//  READ_TIMEOUT    64          max clocks from read accept to cmdReadDataValid
//  ERR_COUNT_WIDTH 16          width of errCount (saturating)
// PORTS
//  clk              in   1   clock, same clock as the SDRAM controller
//  rst              in   1   synchronous, active-high reset
//  start            in   1   1-cycle pulse: begin a test run; ignored while busy
//  busy             out  1   run in progress
//  done             out  1   1-cycle pulse when a run completes
//  pass             out  1   last completed run had errCount==0; held until next start
//  errCount         out  ERR_COUNT_WIDTH  mismatches + timeouts in current/last run
//  firstErrAddr     out  23  address of first mismatch/timeout in run; 0 if none
//  cmdReady         in   1   controller idle and able to accept a command
//  cmdTrigger       out  1   command strobe to controller
//  cmdAddr          out  23  {bank[22:21], row[20:9], col[8:0]}
//  cmdWrite         out  1   1=write, 0=read
//  cmdWriteData     out  16  write data
//  cmdReadData      in   16  read data from controller
//  cmdReadDataValid in   1   cmdReadData valid this cycle
// BEHAVIOUR
//  Reset: state IDLE; busy=0 done=0 pass=0 errCount=0 firstErrAddr=0 cmdTrigger=0
//   cmdAddr=0 cmdWrite=0 cmdWriteData=0. rst mid-run aborts immediately; no done pulse.
//  Handshake: command accepted in the cycle cmdTrigger&&cmdReady. cmdTrigger is registered,
//   high for exactly that one cycle, then low. After an accept, cmdReady is ignored for one
//   cycle (controller leaves idle one edge later). cmdAddr/cmdWrite/cmdWriteData are stable
//   while cmdTrigger is high.
//  FSM:
//   IDLE    : start -> addr=ADDR_FIRST, errCount=0, firstErrAddr=0, pass=0, busy=1 -> WR_ISS
//   WR_ISS  : cmdTrigger=cmdReady, cmdWrite=1, data=pattern(addr); on accept -> WR_GAP
//   WR_GAP  : one guard cycle; addr==ADDR_LAST ? (addr=ADDR_FIRST -> RD_ISS) : (addr+1 -> WR_ISS)
//   RD_ISS  : cmdTrigger=cmdReady, cmdWrite=0; on accept clear timer -> RD_WAIT
//   RD_WAIT : cmdReadDataValid -> compare with pattern(addr); timer==READ_TIMEOUT-1 -> count
//             as error; either case -> RD_NEXT
//   RD_NEXT : addr==ADDR_LAST ? DONE : (addr+1 -> RD_ISS)
//   DONE    : done=1 one cycle, busy=0, pass=(errCount==0) -> IDLE
//  Errors: each mismatch/timeout increments errCount, saturating at all-ones (no wrap). The
//   first error of a run latches firstErrAddr; later errors do not update it.
//  cmdReadDataValid outside RD_WAIT is ignored. A valid in the same cycle as the timeout
//   counts as data (compare), not timeout.
//  Address counter 23 bits; ADDR_LAST=7FFFFF ends without wrap. ADDR_FIRST==ADDR_LAST:
//   exactly one write and one read.
//  start while busy ignored; start in the DONE cycle ignored; accepted in IDLE next cycle.
//  Latency: start -> first cmdTrigger = 2 clocks if cmdReady high.
// CONFIGURATION
//  SDRAM_TESTER_LOOP_EN defined: DONE returns to WR_ISS instead of IDLE and runs forever,
//   XORing pattern with 16'hFFFF on alternate passes (pass 0 normal). errCount and
//   firstErrAddr accumulate across passes; done pulses and pass updates at every pass end;
//   busy stays 1 until rst.
//  Not defined: single run per start as above.
// TESTING  (bench uses behavioural controller model: cmdReady low 3 clks after accept,
//           read data returned 2 clks after accept, backing RAM array)
//  1 ADDR_FIRST=0, ADDR_LAST=15, start -> 16 writes then 16 reads, done pulse, pass=1, errCount=0
//  2 model flips bit0 on read of addr 5 and 9 -> errCount=2, firstErrAddr=5, pass=0
//  3 model drops valid for addr 3 -> timeout after READ_TIMEOUT clks, errCount=1, firstErrAddr=3,
//    run continues and completes addr 4..15
//  4 ERR_COUNT_WIDTH=2, model corrupts all 16 reads -> errCount=3 (saturated), pass=0
//  5 rst asserted during read phase -> next cycle all outputs at reset values, no done; new
//    start runs cleanly to pass=1; start pulses while busy have no effect
//  6 SDRAM_TESTER_LOOP_EN, range 0..3 -> pass 1 writes pattern^FFFF to addr 0, done pulses each
//    pass, busy stays 1

Source files
------------

// File: rtl/sdram_pattern_tester.sv
`timescale 1ns/1ps
// SDRAM bring-up tester: writes an address-derived pattern over a range, reads it back and reports errors.
// Optional SDRAM_TESTER_LOOP_EN: run forever, inverting the pattern on alternate passes.
module sdram_pattern_tester #(
    parameter logic [22:0] ADDR_FIRST      = 23'h000000,
    parameter logic [22:0] ADDR_LAST       = 23'h7FFFFF,
    parameter logic [15:0] PATTERN_SEED    = 16'hA5C3,
    parameter int          READ_TIMEOUT    = 64,
    parameter int          ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_COUNT_WIDTH-1:0] errCount,
    output logic [22:0]                firstErrAddr,
    input  logic                       cmdReady,
    output logic                       cmdTrigger,
    output logic [22:0]                cmdAddr,
    output logic                       cmdWrite,
    output logic [15:0]                cmdWriteData,
    input  logic [15:0]                cmdReadData,
    input  logic                       cmdReadDataValid
);

    localparam int TW = $clog2(READ_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(READ_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ISS  = 3'd1,
        ST_WR_GAP  = 3'd2,
        ST_RD_ISS  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_NEXT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    state_t                     state_r, state_s;
    logic [22:0]                addr_r, addr_s;
    logic [TW-1:0]              timer_r, timer_s;
    logic                       invert_r, invert_s;
    logic                       busy_r, busy_s;
    logic                       done_r, done_s;
    logic                       pass_r, pass_s;
    logic [ERR_COUNT_WIDTH-1:0] err_count_r, err_count_s;
    logic [22:0]                first_err_addr_r, first_err_addr_s;
    logic                       cmd_trigger_r, cmd_trigger_s;
    logic [22:0]                cmd_addr_r, cmd_addr_s;
    logic                       cmd_write_r, cmd_write_s;
    logic [15:0]                cmd_write_data_r, cmd_write_data_s;
    logic                       err_hit_s;
    logic                       accept_s;

    function automatic logic [15:0] pattern_word(input logic [22:0] addr, input logic inv);
        return addr[15:0] ^ addr[22:7] ^ PATTERN_SEED ^ {16{inv}};
    endfunction

    assign accept_s = cmd_trigger_r && cmdReady;

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_s          = state_r;
        addr_s           = addr_r;
        timer_s          = timer_r;
        invert_s         = invert_r;
        busy_s           = busy_r;
        done_s           = 1'b0;
        pass_s           = pass_r;
        err_count_s      = err_count_r;
        first_err_addr_s = first_err_addr_r;
        cmd_trigger_s    = 1'b0;
        cmd_addr_s       = cmd_addr_r;
        cmd_write_s      = cmd_write_r;
        cmd_write_data_s = cmd_write_data_r;
        err_hit_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_s           = ADDR_FIRST;
                    err_count_s      = '0;
                    first_err_addr_s = 23'd0;
                    pass_s           = 1'b0;
                    busy_s           = 1'b1;
                    invert_s         = 1'b0;
                    state_s          = ST_WR_ISS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_ISS: begin
                // A strobe that was not accepted drops for a cycle before retrying.
                if (accept_s) begin
                    state_s = ST_WR_GAP;
                end else if (!cmd_trigger_r && cmdReady) begin
                    cmd_trigger_s    = 1'b1;
                    cmd_addr_s       = addr_r;
                    cmd_write_s      = 1'b1;
                    cmd_write_data_s = pattern_word(addr_r, invert_r);
                end else begin
                    state_s = ST_WR_ISS;
                end
            end
            ST_WR_GAP: begin
                if (addr_r == ADDR_LAST) begin
                    addr_s  = ADDR_FIRST;
                    state_s = ST_RD_ISS;
                end else begin
                    addr_s  = addr_r + 23'd1;
                    state_s = ST_WR_ISS;
                end
            end
            ST_RD_ISS: begin
                if (accept_s) begin
                    timer_s = '0;
                    state_s = ST_RD_WAIT;
                end else if (!cmd_trigger_r && cmdReady) begin
                    cmd_trigger_s = 1'b1;
                    cmd_addr_s    = addr_r;
                    cmd_write_s   = 1'b0;
                end else begin
                    state_s = ST_RD_ISS;
                end
            end
            ST_RD_WAIT: begin
                // Data arriving on the timeout cycle is compared, not counted as a timeout.
                if (cmdReadDataValid) begin
                    err_hit_s = (cmdReadData != pattern_word(addr_r, invert_r));
                    state_s   = ST_RD_NEXT;
                end else if (timer_r == TIMER_LAST) begin
                    err_hit_s = 1'b1;
                    state_s   = ST_RD_NEXT;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_RD_NEXT: begin
                if (addr_r == ADDR_LAST) begin
                    done_s  = 1'b1;
                    pass_s  = (err_count_r == '0);
`ifdef SDRAM_TESTER_LOOP_EN
                    busy_s  = 1'b1;
`else
                    busy_s  = 1'b0;
`endif
                    state_s = ST_DONE;
                end else begin
                    addr_s  = addr_r + 23'd1;
                    state_s = ST_RD_ISS;
                end
            end
            ST_DONE: begin
`ifdef SDRAM_TESTER_LOOP_EN
                addr_s   = ADDR_FIRST;
                invert_s = ~invert_r;
                state_s  = ST_WR_ISS;
`else
                state_s  = ST_IDLE;
`endif
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
        if (err_hit_s) begin
            if (err_count_r != '1) begin
                err_count_s = err_count_r + ERR_COUNT_WIDTH'(1);
            end else begin
                err_count_s = err_count_r;
            end
            if (err_count_r == '0) begin
                first_err_addr_s = addr_r;
            end else begin
                first_err_addr_s = first_err_addr_r;
            end
        end else begin
            err_count_s = err_count_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            addr_r           <= 23'd0;
            timer_r          <= '0;
            invert_r         <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_count_r      <= '0;
            first_err_addr_r <= 23'd0;
            cmd_trigger_r    <= 1'b0;
            cmd_addr_r       <= 23'd0;
            cmd_write_r      <= 1'b0;
            cmd_write_data_r <= 16'd0;
        end else begin
            state_r          <= state_s;
            addr_r           <= addr_s;
            timer_r          <= timer_s;
            invert_r         <= invert_s;
            busy_r           <= busy_s;
            done_r           <= done_s;
            pass_r           <= pass_s;
            err_count_r      <= err_count_s;
            first_err_addr_r <= first_err_addr_s;
            cmd_trigger_r    <= cmd_trigger_s;
            cmd_addr_r       <= cmd_addr_s;
            cmd_write_r      <= cmd_write_s;
            cmd_write_data_r <= cmd_write_data_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign errCount     = err_count_r;
    assign firstErrAddr = first_err_addr_r;
    assign cmdTrigger   = cmd_trigger_r;
    assign cmdAddr      = cmd_addr_r;
    assign cmdWrite     = cmd_write_r;
    assign cmdWriteData = cmd_write_data_r;

endmodule
